// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two req/ack masters onto one data memory via IDLE/ACCESS/ACK.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_WORDS * 4);

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    we_q, we_d;
  logic                    bad_q, bad_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic                    ack0_q, ack0_d, ack1_q, ack1_d;
  logic                    err0_q, err0_d, err1_q, err1_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                    busy_q, busy_d;

  logic                    grant1_s;
  logic                    sel_we_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic                    sel_bad_s;
  logic [DATA_WIDTH-1:0]   rd_val_s;

  // Winner selection and the winner's request fields.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    // owner_q is the last port granted; on a tie the other port goes next.
    if (req0 && req1) begin
      grant1_s = ~owner_q;
    end else begin
      grant1_s = ~req0;
    end
`else
    grant1_s = ~req0;
`endif
    if (grant1_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
    sel_bad_s = (sel_addr_s[1:0] != 2'b00) || (sel_addr_s >= ADDR_LIMIT);
    rd_val_s  = bad_q ? {DATA_WIDTH{1'b0}} : mem_rdata;
  end

  // Next-state and next-output logic of the transaction FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    bad_d       = bad_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    busy_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d     = ACCESS;
          owner_d     = grant1_s;
          we_d        = sel_we_s;
          bad_d       = sel_bad_s;
          mem_addr_d  = sel_addr_s;
          mem_wdata_d = sel_wdata_s;
          mem_write_d = ~sel_bad_s & sel_we_s;
          mem_read_d  = ~sel_bad_s & ~sel_we_s;
          busy_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = ACK;
        busy_d  = 1'b1;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        err0_d  = ~owner_q & bad_q;
        err1_d  = owner_q & bad_q;
        // Memory read data is combinational, so it is captured on this edge.
        if (!we_q && owner_q) begin
          rdata1_d = rd_val_s;
        end else if (!we_q) begin
          rdata0_d = rd_val_s;
        end else begin
          rdata0_d = rdata0_q;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; owner resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b1;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= {DATA_WIDTH{1'b0}};
      rdata1_q    <= {DATA_WIDTH{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      bad_q       <= bad_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
